// File: rtl/rv_test_harness_ctrl.sv
// Run controller for RV32 regression: sequences the core reset, counts RUN cycles,
// snoops tohost stores for end-of-test and enforces a watchdog.
module rv_test_harness_ctrl #(
  parameter int unsigned          ADDR_W          = 32,
  parameter int unsigned          DATA_W          = 32,
  parameter int unsigned          CNT_W           = 32,
  parameter int unsigned          RST_HOLD_CYCLES = 3,
  parameter int unsigned          TIMEOUT_CYCLES  = 30,
  parameter logic [ADDR_W-1:0]    TOHOST_ADDR     = 32'h0000_0FFC,
  parameter logic [DATA_W-1:0]    PASS_CODE       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned HoldLoad = (RST_HOLD_CYCLES == 0) ? 1 : RST_HOLD_CYCLES;
  localparam int unsigned HoldW    = $clog2(HoldLoad + 1);

  typedef enum logic [1:0] {StIdle, StResetHold, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic                tohost_hit;
  logic                wd_expire;
  logic [CNT_W-1:0]    cycle_count_inc;

  assign tohost_hit      = mem_we && (mem_addr == TOHOST_ADDR);
  assign cycle_count_inc = cycle_count_q + 1'b1;
  assign wd_expire       = (cycle_count_inc == CNT_W'(TIMEOUT_CYCLES));

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      core_rst_n_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      result_q      <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      core_rst_n_q  <= core_rst_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
      result_q      <= result_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StResetHold;
      StResetHold:    if (hold_q == HoldW'(1)) state_d = StRun;
      StRun:          if (tohost_hit || wd_expire) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  // Output/datapath next values; outputs are registered from the upcoming state.
  always_comb begin
    hold_d        = hold_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;
    result_d      = result_q;
    core_rst_n_d  = (state_d == StRun);
    busy_d        = (state_d == StResetHold) || (state_d == StRun);

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          hold_d        = HoldW'(HoldLoad);
          done_d        = 1'b0;
          pass_d        = 1'b0;
          fail_d        = 1'b0;
          timeout_d     = 1'b0;
          cycle_count_d = '0;
          result_d      = '0;
        end
      end
      StResetHold: hold_d = hold_q - 1'b1;
      StRun: begin
        cycle_count_d = cycle_count_inc;
        // A tohost hit on the watchdog edge takes priority over the timeout.
        if (tohost_hit) begin
          result_d = mem_wdata;
          done_d   = 1'b1;
          pass_d   = (mem_wdata == PASS_CODE);
          fail_d   = (mem_wdata != PASS_CODE);
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          fail_d    = 1'b1;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign core_rst_n  = core_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;
  assign result      = result_q;

endmodule
